ram_march_tester: RTL and testbench

- Initiator-side controller for the team's single-port synchronous RAM (data_in / address / write_enable / data_out). Until now that port has only been driven by hand-written benches.
- Runs a 4-element March test over every address and compares read data against expected values in-line. Reports pass/fail, first failing location and an error count.
- Sits between a system-level test sequencer (start/done) and one RAM instance. During test it owns the RAM port.

---
 rtl/ram_march_tester.sv | 260 ++++++++++++++++++++++++++
 tb/tb_ram_march_tester.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_march_tester.sv
// March test controller for a single-port synchronous RAM.
// Runs W(P) up / R(P)W(~P) up / R(~P)W(P) down / R(P) up, checks every
// read in-line and reports pass, error count and the first failing word.
module ram_march_tester #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 6,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] pattern,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [7:0]        err_count,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W-1:0] fail_expected,
   output logic [DATA_W-1:0] fail_actual,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [3:0] {
      IDLE  = 4'd0,
      M0_W  = 4'd1,
      M1_R  = 4'd2,
      M1_W  = 4'd3,
      M2_R  = 4'd4,
      M2_W  = 4'd5,
      M3_R  = 4'd6,
      DRAIN = 4'd7,
      DONE  = 4'd8
   } state_t;

   localparam logic [ADDR_W-1:0] ADDR_MAX   = {ADDR_W{1'b1}};
   localparam logic [ADDR_W-1:0] ADDR_ZERO  = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
   localparam logic [DATA_W-1:0] DATA_ZERO  = {DATA_W{1'b0}};
   localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT - 1);

   state_t              state_q;
   logic [DATA_W-1:0]   pat_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                we_q;
   logic                busy_q;
   logic                done_q;
   logic                pass_q;
   logic [7:0]          err_q;
   logic [ADDR_W-1:0]   fail_addr_q;
   logic [DATA_W-1:0]   fail_exp_q;
   logic [DATA_W-1:0]   fail_act_q;
   logic [1:0]          drain_q;

   // Compare pipeline: one stage per cycle of RAM read latency.
   logic                pv_q [RD_LAT];
   logic [ADDR_W-1:0]   pa_q [RD_LAT];
   logic [DATA_W-1:0]   pe_q [RD_LAT];

   logic                rd_valid_d;
   logic [DATA_W-1:0]   rd_exp_d;
   logic                mismatch_d;

   // Classify the access currently on the RAM port: is it a read, and what must it return.
   always_comb begin
      rd_valid_d = 1'b0;
      rd_exp_d   = DATA_ZERO;
      case (state_q)
         M1_R: begin
            rd_valid_d = 1'b1;
            rd_exp_d   = pat_q;
         end
         M2_R: begin
            rd_valid_d = 1'b1;
            rd_exp_d   = ~pat_q;
         end
         M3_R: begin
            rd_valid_d = 1'b1;
            rd_exp_d   = pat_q;
         end
         default: begin
            rd_valid_d = 1'b0;
            rd_exp_d   = DATA_ZERO;
         end
      endcase
      if (pv_q[RD_LAT-1]) begin
         mismatch_d = (mem_rdata != pe_q[RD_LAT-1]);
      end else begin
         mismatch_d = 1'b0;
      end
   end

   // Shift read descriptors so each meets its data when the RAM returns it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RD_LAT; i++) begin
            pv_q[i] <= 1'b0;
            pa_q[i] <= ADDR_ZERO;
            pe_q[i] <= DATA_ZERO;
         end
      end else begin
         pv_q[0] <= rd_valid_d;
         pa_q[0] <= addr_q;
         pe_q[0] <= rd_exp_d;
         for (int i = 1; i < RD_LAT; i++) begin
            pv_q[i] <= pv_q[i-1];
            pa_q[i] <= pa_q[i-1];
            pe_q[i] <= pe_q[i-1];
         end
      end
   end

   // March sequencer with registered RAM port, status and error bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pat_q       <= DATA_ZERO;
         addr_q      <= ADDR_ZERO;
         wdata_q     <= DATA_ZERO;
         we_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         err_q       <= 8'd0;
         fail_addr_q <= ADDR_ZERO;
         fail_exp_q  <= DATA_ZERO;
         fail_act_q  <= DATA_ZERO;
         drain_q     <= 2'd0;
      end else begin
         done_q <= 1'b0;
         if (mismatch_d) begin
            if (err_q != 8'd255) begin
               err_q <= err_q + 8'd1;
            end
            if (err_q == 8'd0) begin
               fail_addr_q <= pa_q[RD_LAT-1];
               fail_exp_q  <= pe_q[RD_LAT-1];
               fail_act_q  <= mem_rdata;
            end
         end
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q     <= M0_W;
                  pat_q       <= pattern;
                  addr_q      <= ADDR_ZERO;
                  wdata_q     <= pattern;
                  we_q        <= 1'b1;
                  busy_q      <= 1'b1;
                  pass_q      <= 1'b0;
                  err_q       <= 8'd0;
                  fail_addr_q <= ADDR_ZERO;
                  fail_exp_q  <= DATA_ZERO;
                  fail_act_q  <= DATA_ZERO;
               end else begin
                  addr_q  <= ADDR_ZERO;
                  wdata_q <= DATA_ZERO;
                  we_q    <= 1'b0;
               end
            end
            M0_W: begin
               if (addr_q == ADDR_MAX) begin
                  state_q <= M1_R;
                  addr_q  <= ADDR_ZERO;
                  wdata_q <= DATA_ZERO;
                  we_q    <= 1'b0;
               end else begin
                  addr_q  <= addr_q + ADDR_ONE;
                  wdata_q <= pat_q;
                  we_q    <= 1'b1;
               end
            end
            M1_R: begin
               state_q <= M1_W;
               wdata_q <= ~pat_q;
               we_q    <= 1'b1;
            end
            M1_W: begin
               if (addr_q == ADDR_MAX) begin
                  state_q <= M2_R;
                  addr_q  <= ADDR_MAX;
               end else begin
                  state_q <= M1_R;
                  addr_q  <= addr_q + ADDR_ONE;
               end
               wdata_q <= DATA_ZERO;
               we_q    <= 1'b0;
            end
            M2_R: begin
               state_q <= M2_W;
               wdata_q <= pat_q;
               we_q    <= 1'b1;
            end
            M2_W: begin
               if (addr_q == ADDR_ZERO) begin
                  state_q <= M3_R;
               end else begin
                  state_q <= M2_R;
                  addr_q  <= addr_q - ADDR_ONE;
               end
               wdata_q <= DATA_ZERO;
               we_q    <= 1'b0;
            end
            M3_R: begin
               if (addr_q == ADDR_MAX) begin
                  state_q <= DRAIN;
                  addr_q  <= ADDR_ZERO;
                  drain_q <= 2'd0;
               end else begin
                  addr_q <= addr_q + ADDR_ONE;
               end
               wdata_q <= DATA_ZERO;
               we_q    <= 1'b0;
            end
            DRAIN: begin
               if (drain_q == DRAIN_LAST) begin
                  state_q <= DONE;
                  drain_q <= 2'd0;
               end else begin
                  drain_q <= drain_q + 2'd1;
               end
               addr_q  <= ADDR_ZERO;
               wdata_q <= DATA_ZERO;
               we_q    <= 1'b0;
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               pass_q  <= (err_q == 8'd0);
               addr_q  <= ADDR_ZERO;
               wdata_q <= DATA_ZERO;
               we_q    <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               addr_q  <= ADDR_ZERO;
               wdata_q <= DATA_ZERO;
               we_q    <= 1'b0;
            end
         endcase
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign pass          = pass_q;
   assign err_count     = err_q;
   assign fail_addr     = fail_addr_q;
   assign fail_expected = fail_exp_q;
   assign fail_actual   = fail_act_q;
   assign mem_addr      = addr_q;
   assign mem_wdata     = wdata_q;
   assign mem_we        = we_q;

endmodule

// File: tb/tb_ram_march_tester.sv
// Directed bench for ram_march_tester with behavioural RAM models
// (1-cycle RAM on the default build, 2-cycle RAM on an RD_LAT=2 build).
module tb_ram_march_tester;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] pattern;
   logic       busy, done, pass;
   logic [7:0] err_count;
   logic [5:0] fail_addr;
   logic [7:0] fail_expected, fail_actual;
   logic [5:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       mem_we;
   logic [7:0] mem_rdata;

   logic       start2;
   logic [7:0] pattern2;
   logic       busy2, done2, pass2;
   logic [7:0] err_count2;
   logic [5:0] fail_addr2;
   logic [7:0] fail_expected2, fail_actual2;
   logic [5:0] mem_addr2;
   logic [7:0] mem_wdata2;
   logic       mem_we2;
   logic [7:0] mem_rdata2;

   logic       fault_en;
   logic [7:0] ram0 [64];
   logic [7:0] ram1 [64];
   logic [7:0] rd1_a, rd1_b;

   int n_checks;
   int n_errors;

   ram_march_tester dut (
      .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .fail_addr(fail_addr), .fail_expected(fail_expected), .fail_actual(fail_actual),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
   );

   ram_march_tester #(.RD_LAT(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .pattern(pattern2),
      .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
      .fail_addr(fail_addr2), .fail_expected(fail_expected2), .fail_actual(fail_actual2),
      .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_we(mem_we2), .mem_rdata(mem_rdata2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 1-cycle RAM with optional bit-0 stuck-at-1 at address 7.
   always @(posedge clk) begin
      if (mem_we) ram0[mem_addr] <= mem_wdata;
      if (fault_en && mem_addr == 6'd7) rd1_a <= ram0[mem_addr] | 8'h01;
      else                               rd1_a <= ram0[mem_addr];
   end
   assign mem_rdata = rd1_a;

   // 2-cycle RAM for the RD_LAT=2 instance.
   always @(posedge clk) begin
      if (mem_we2) ram1[mem_addr2] <= mem_wdata2;
      rd1_b      <= ram1[mem_addr2];
      mem_rdata2 <= rd1_b;
   end

   task automatic launch(input logic [7:0] pat);
      @(negedge clk);
      start   = 1'b1;
      pattern = pat;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output int done_k);
      int k;
      k = 0;
      done_k = -1;
      while (k < 600 && done_k < 0) begin
         if (done) done_k = k;
         else begin
            @(posedge clk); #1; k++;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #3;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, pass, mem_we} !== 4'b0000) begin
         n_errors++;
         $display("FAIL reset_flags busy/done/pass/we=%b expected 0000", {busy, done, pass, mem_we});
      end
      n_checks++;
      if (err_count !== 8'd0 || fail_addr !== 6'd0 || fail_expected !== 8'd0 || fail_actual !== 8'd0) begin
         n_errors++;
         $display("FAIL reset_status err=%0d faddr=%0d fexp=%h fact=%h expected all 0",
                  err_count, fail_addr, fail_expected, fail_actual);
      end
      n_checks++;
      if (mem_addr !== 6'd0 || mem_wdata !== 8'd0) begin
         n_errors++;
         $display("FAIL reset_port addr=%0d wdata=%h expected 0/00", mem_addr, mem_wdata);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_pattern_55();
      int k;
      int done_k;
      launch(8'h55);
      k = 0;
      done_k = -1;
      while (k < 600 && done_k < 0) begin
         if (k < 64) begin
            n_checks++;
            if (mem_we !== 1'b1 || mem_addr !== k[5:0] || mem_wdata !== 8'h55) begin
               n_errors++;
               $display("FAIL m0_write k=%0d we=%b addr=%0d data=%h expected we=1 addr=%0d data=55",
                        k, mem_we, mem_addr, mem_wdata, k);
            end
         end
         if (k == 385) begin
            n_checks++;
            if (busy !== 1'b1) begin
               n_errors++;
               $display("FAIL busy_before_done busy=%b expected 1", busy);
            end
         end
         if (done) done_k = k;
         else begin
            @(posedge clk); #1; k++;
         end
      end
      n_checks++;
      if (done_k != 386) begin
         n_errors++;
         $display("FAIL done_latency_55 got=%0d expected 386", done_k);
      end
      n_checks++;
      if (pass !== 1'b1 || err_count !== 8'd0 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL result_55 pass=%b err=%0d busy=%b expected 1/0/0", pass, err_count, busy);
      end
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b0 || pass !== 1'b1) begin
         n_errors++;
         $display("FAIL done_pulse_hold done=%b pass=%b expected 0/1", done, pass);
      end
   endtask

   task automatic test_pattern_a3();
      int k;
      int done_k;
      int j;
      launch(8'hA3);
      k = 0;
      done_k = -1;
      while (k < 600 && done_k < 0) begin
         if (k >= 64 && k < 192) begin
            n_checks++;
            if (mem_we !== k[0] || (mem_we === 1'b1 && mem_wdata !== 8'h5C)) begin
               n_errors++;
               $display("FAIL m1_access k=%0d we=%b data=%h expected we=%0d data=5c", k, mem_we, mem_wdata, k[0]);
            end
         end
         if (k >= 192 && k < 320) begin
            j = 63 - (k - 192) / 2;
            n_checks++;
            if (mem_addr !== j[5:0] || mem_we !== k[0]) begin
               n_errors++;
               $display("FAIL m2_access k=%0d addr=%0d we=%b expected addr=%0d we=%0d", k, mem_addr, mem_we, j, k[0]);
            end
         end
         if (done) done_k = k;
         else begin
            @(posedge clk); #1; k++;
         end
      end
      n_checks++;
      if (done_k != 386 || pass !== 1'b1 || err_count !== 8'd0) begin
         n_errors++;
         $display("FAIL result_a3 done_k=%0d pass=%b err=%0d expected 386/1/0", done_k, pass, err_count);
      end
   endtask

   task automatic test_stuck_bit();
      int done_k;
      fault_en = 1'b1;
      launch(8'h00);
      n_checks++;
      if (pass !== 1'b0 || busy !== 1'b1) begin
         n_errors++;
         $display("FAIL start_clears pass=%b busy=%b expected 0/1", pass, busy);
      end
      wait_done(done_k);
      n_checks++;
      if (done_k != 386 || err_count !== 8'd2) begin
         n_errors++;
         $display("FAIL stuck_err done_k=%0d err=%0d expected 386/2", done_k, err_count);
      end
      n_checks++;
      if (fail_addr !== 6'd7 || fail_expected !== 8'h00 || fail_actual !== 8'h01) begin
         n_errors++;
         $display("FAIL stuck_capture addr=%0d exp=%h act=%h expected 7/00/01", fail_addr, fail_expected, fail_actual);
      end
      n_checks++;
      if (pass !== 1'b0) begin
         n_errors++;
         $display("FAIL stuck_pass pass=%b expected 0", pass);
      end
      fault_en = 1'b0;
   endtask

   task automatic test_restart_ignored();
      int k;
      int first_k;
      int pulses;
      launch(8'h55);
      k = 0;
      first_k = -1;
      pulses = 0;
      while (k < 400) begin
         if (k == 100) start = 1'b1;
         if (k == 101) start = 1'b0;
         if (done) begin
            pulses++;
            if (first_k < 0) first_k = k;
         end
         @(posedge clk); #1; k++;
      end
      n_checks++;
      if (first_k != 386 || pulses != 1) begin
         n_errors++;
         $display("FAIL restart_ignored done_k=%0d pulses=%0d expected 386/1", first_k, pulses);
      end
   endtask

   task automatic test_reset_mid_run();
      int done_k;
      launch(8'h55);
      repeat (101) begin
         @(posedge clk); #1;
      end
      n_checks++;
      if (mem_we !== 1'b1 || busy !== 1'b1) begin
         n_errors++;
         $display("FAIL pre_reset we=%b busy=%b expected 1/1", mem_we, busy);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (mem_we !== 1'b0 || busy !== 1'b0 || mem_addr !== 6'd0 || mem_wdata !== 8'd0) begin
         n_errors++;
         $display("FAIL async_reset we=%b busy=%b addr=%0d data=%h expected 0/0/0/00",
                  mem_we, busy, mem_addr, mem_wdata);
      end
      @(negedge clk);
      rst_n = 1'b1;
      launch(8'h3C);
      wait_done(done_k);
      n_checks++;
      if (done_k != 386 || pass !== 1'b1 || err_count !== 8'd0) begin
         n_errors++;
         $display("FAIL after_reset done_k=%0d pass=%b err=%0d expected 386/1/0", done_k, pass, err_count);
      end
   endtask

   task automatic test_rd_lat2();
      int k;
      int done_k;
      @(negedge clk);
      start2   = 1'b1;
      pattern2 = 8'h0F;
      @(posedge clk); #1;
      start2 = 1'b0;
      k = 0;
      done_k = -1;
      while (k < 600 && done_k < 0) begin
         if (done2) done_k = k;
         else begin
            @(posedge clk); #1; k++;
         end
      end
      n_checks++;
      if (done_k != 387) begin
         n_errors++;
         $display("FAIL rdlat2_latency got=%0d expected 387", done_k);
      end
      n_checks++;
      if (pass2 !== 1'b1 || err_count2 !== 8'd0) begin
         n_errors++;
         $display("FAIL rdlat2_result pass=%b err=%0d expected 1/0", pass2, err_count2);
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      start    = 1'b0;
      pattern  = 8'h00;
      start2   = 1'b0;
      pattern2 = 8'h00;
      fault_en = 1'b0;
      test_reset();
      test_pattern_55();
      test_pattern_a3();
      test_stuck_bit();
      test_restart_ignored();
      test_reset_mid_run();
      test_rd_lat2();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
